// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone-to-OpenRAM bank bridge.
// Widths are derived from the bridge parameters through the helper functions below.
package wb_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Idle levels of the active-low SRAM strobes.
  localparam logic RAM_WEB_RST = 1'b1;
  localparam logic RAM_CSB_RST = 1'b1;

  // Byte-offset bits inside one data word.
  function automatic int wl_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Bank-select bits.
  function automatic int bw_of(input int num_banks);
    return $clog2(num_banks);
  endfunction

endpackage

// File: rtl/wb_sram_addr_dec.sv
// Splits a Wishbone byte address into window hit, bank index and word index.
// Purely combinational; the byte-offset bits below the word index are ignored.
module wb_sram_addr_dec
  import wb_sram_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 9,
  parameter int          NUM_BANKS = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  localparam int         BW        = bw_of(NUM_BANKS)
) (
  input  logic [31:0]       wbs_adr_i,
  output logic              hit,
  output logic [BW-1:0]     bank,
  output logic [ADDR_W-1:0] word
);

  localparam int WL  = wl_of(DATA_W);
  localparam int TOP = WL + ADDR_W + BW;

  logic unused_lsb;

  assign word = wbs_adr_i[WL +: ADDR_W];
  assign bank = wbs_adr_i[WL + ADDR_W +: BW];
  assign hit  = (wbs_adr_i >> TOP) == (BASE_ADDR >> TOP);

  generate
    if (WL > 0) begin : g_lsb
      assign unused_lsb = ^wbs_adr_i[WL-1:0];
    end else begin : g_no_lsb
      assign unused_lsb = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/wb_sram_bank_bridge.sv
// Wishbone classic slave giving the host direct read/write access to the banked
// OpenRAM macros; hold_i keeps new accesses off the macros while the core owns them.
module wb_sram_bank_bridge
  import wb_sram_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 9,
  parameter int          NUM_BANKS = 8,
  parameter int          READ_LAT  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_we_i,
  input  logic [DATA_W/8-1:0]         wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [DATA_W-1:0]           wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [DATA_W-1:0]           wbs_dat_o,
  input  logic                        hold_i,
  output logic                        busy_o,
  output logic [NUM_BANKS-1:0]        ram_csb,
  output logic                        ram_web,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  output logic [DATA_W/8-1:0]         ram_wmask,
  input  logic [NUM_BANKS*DATA_W-1:0] ram_rdata
);

  localparam int       BW       = bw_of(NUM_BANKS);
  localparam int       SEL_W    = DATA_W / 8;
  localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

  state_t               state;
  logic [2:0]           wait_cnt;
  logic                 hit_q;
  logic                 we_q;
  logic [BW-1:0]        bank_q;

  logic                 dec_hit;
  logic [BW-1:0]        dec_bank;
  logic [ADDR_W-1:0]    dec_word;
  logic [NUM_BANKS-1:0] bank_onehot;
  logic                 start;

  wb_sram_addr_dec #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NUM_BANKS (NUM_BANKS),
    .BASE_ADDR (BASE_ADDR)
  ) u_dec (
    .wbs_adr_i (wbs_adr_i),
    .hit       (dec_hit),
    .bank      (dec_bank),
    .word      (dec_word)
  );

  assign bank_onehot = {{(NUM_BANKS-1){1'b0}}, 1'b1} << dec_bank;
  assign start       = wbs_stb_i & wbs_cyc_i & ~hold_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      hit_q     <= 1'b0;
      we_q      <= 1'b0;
      bank_q    <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      busy_o    <= 1'b0;
      ram_csb   <= {NUM_BANKS{RAM_CSB_RST}};
      ram_web   <= RAM_WEB_RST;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wmask <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_ACCESS;
            busy_o    <= 1'b1;
            hit_q     <= dec_hit;
            we_q      <= wbs_we_i;
            bank_q    <= dec_bank;
            ram_addr  <= dec_word;
            ram_wdata <= wbs_dat_i;
            ram_wmask <= wbs_we_i ? wbs_sel_i : {SEL_W{1'b0}};
            ram_web   <= ~wbs_we_i;
            // A miss leaves every macro deselected but still runs the handshake.
            ram_csb   <= dec_hit ? ~bank_onehot : {NUM_BANKS{RAM_CSB_RST}};
          end
        end

        ST_ACCESS: begin
          ram_csb <= {NUM_BANKS{RAM_CSB_RST}};
          ram_web <= RAM_WEB_RST;
          if (!wbs_cyc_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (we_q || !hit_q) begin
            state     <= ST_RESP;
            wbs_ack_o <= 1'b1;
            if (!we_q) wbs_dat_o <= '0;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= LAT_LAST;
          end
        end

        ST_WAIT: begin
          if (!wbs_cyc_i) begin
            state    <= ST_IDLE;
            busy_o   <= 1'b0;
            wait_cnt <= '0;
          end else if (wait_cnt == 3'd0) begin
            state     <= ST_RESP;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= ram_rdata[int'(bank_q) * DATA_W +: DATA_W];
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        ST_RESP: begin
          state     <= ST_IDLE;
          wbs_ack_o <= 1'b0;
          busy_o    <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          wbs_ack_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule
